data_compress_arb: RTL and testbench

- Shares one data_compress instance between NREQ byte-stream requesters.
- Round-robin arbitration at packet granularity: a granted requester keeps the compressor until its last beat, so compression history never interleaves between streams.
- Drives the compressor's din/den/hold and inserts one idle gap between packets.
- Routes compressed output back to the owning requester using a tag FIFO (requester id + last flag).
- Sits between stream sources and data_compress.

---
 rtl/data_compress_pkg.sv | 17 +
 rtl/dc_tag_fifo.sv | 50 +++++
 rtl/data_compress_arb.sv | 178 +++++++++++++++++
 tb/tb_data_compress_arb.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_compress_pkg.sv
// Shared types for the data_compress requester arbiter.
package data_compress_pkg;

  localparam int unsigned DW_DEF  = 8;
  localparam int unsigned ID_MAXW = 3;

  typedef enum logic [1:0] {IDLE, ARB, XFER, GAP} arb_state_e;

  // Sized for up to 8 requesters; the top narrows id to its own width.
  typedef struct packed {
    logic [ID_MAXW-1:0] id;
    logic               last;
  } tag_t;

  localparam int unsigned TAG_W = $bits(tag_t);

endpackage

// File: rtl/dc_tag_fifo.sv
// Synchronous FIFO holding {requester id, last} for beats inside the compressor.
module dc_tag_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push_ok, pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/data_compress_arb.sv
// Packet-granular round-robin sharing of one data_compress among NREQ streams,
// with tag-based routing of compressed bytes back to their owner.
module data_compress_arb
  import data_compress_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned TAG_DEPTH = 4,
  parameter int unsigned IDW       = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]    req_hold,
  input  logic [NREQ-1:0]    req_last,
  output logic [NREQ-1:0]    req_ready,
  output logic [DW-1:0]      c_din,
  output logic               c_den,
  output logic               c_hold,
  input  logic               c_rdy,
  input  logic [DW-1:0]      c_dout,
  input  logic               c_vldo,
  output logic [DW-1:0]      out_data,
  output logic               out_valid,
  output logic [IDW-1:0]     out_id,
  output logic               out_last,
  output logic [IDW-1:0]     grant_id,
  output logic               busy,
  output logic               err
);

  localparam int unsigned CW = $clog2(TAG_DEPTH + 1);

  arb_state_e     state, state_n;
  logic [IDW-1:0] rr, rr_n, grant_n;
  logic [IDW-1:0] pick, pick_hi, pick_lo;
  logic           pick_hi_vld, pick_lo_vld;
  logic [DW-1:0]  sel_data;
  logic           sel_valid, sel_hold, sel_last;
  logic           xfer_ready, accept, pop;
  logic [CW-1:0]  tag_count;
  logic           tag_full, tag_empty;
  tag_t           push_tag, head;

  // Lowest valid index at or above rr, else lowest valid overall (wrap).
  always_comb begin
    pick_hi     = '0;
    pick_lo     = '0;
    pick_hi_vld = 1'b0;
    pick_lo_vld = 1'b0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        pick_lo     = IDW'(i);
        pick_lo_vld = 1'b1;
        if (IDW'(i) >= rr) begin
          pick_hi     = IDW'(i);
          pick_hi_vld = 1'b1;
        end
      end
    end
    pick = pick_hi_vld ? pick_hi : pick_lo;
  end

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_hold  = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant_id == IDW'(i)) begin
        sel_data  = req_data[i*DW +: DW];
        sel_valid = req_valid[i];
        sel_hold  = req_hold[i];
        sel_last  = req_last[i];
      end
    end
  end

  assign xfer_ready = c_rdy & (tag_count < CW'(TAG_DEPTH));
  assign accept     = (state == XFER) & sel_valid & xfer_ready;
  assign pop        = c_vldo & ~tag_empty;
  assign busy       = (state != IDLE) | ~tag_empty;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (state == XFER && grant_id == IDW'(i)) req_ready[i] = xfer_ready;
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant_id;
    rr_n    = rr;
    case (state)
      IDLE: if (|req_valid) state_n = ARB;
      ARB: begin
        if (pick_lo_vld) begin
          grant_n = pick;
          rr_n    = (pick == IDW'(NREQ - 1)) ? '0 : pick + IDW'(1);
          state_n = XFER;
        end else begin
          state_n = IDLE;
        end
      end
      XFER:    if (accept && sel_last) state_n = GAP;
      GAP:     state_n = (|req_valid) ? ARB : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr       <= '0;
      grant_id <= '0;
    end else begin
      state    <= state_n;
      rr       <= rr_n;
      grant_id <= grant_n;
    end
  end

  // Compressor drive and owner-tagged output path.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_din     <= '0;
      c_hold    <= 1'b0;
      c_den     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      out_last  <= 1'b0;
      err       <= 1'b0;
    end else begin
      c_den     <= accept;
      out_valid <= pop;
      if (accept) begin
        c_din  <= sel_data;
        c_hold <= sel_hold;
      end
      if (pop) begin
        out_data <= c_dout;
        out_id   <= IDW'(head.id);
        out_last <= head.last;
      end
      if (c_vldo && tag_empty) err <= 1'b1;
    end
  end

  always_comb begin
    push_tag      = '0;
    push_tag.id   = ID_MAXW'(grant_id);
    push_tag.last = sel_last;
  end

  dc_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .W     (TAG_W),
    .CW    (CW)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .din   (push_tag),
    .pop   (pop),
    .dout  (head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  // Ready is gated on count, so full only matters inside the FIFO.
  logic unused_full;
  assign unused_full = tag_full;

endmodule

// File: tb/tb_data_compress_arb.sv
// Bench for data_compress_arb: stimulus tables, a fake compressor and scoreboard queues.
module tb_data_compress_arb;
  import data_compress_pkg::*;

  localparam int unsigned NREQ = 4, DW = 8, TAG_DEPTH = 4, IDW = 2;

  typedef struct packed {logic [7:0] data; logic hold; logic last;} beat_t;
  typedef struct packed {logic [7:0] data; logic [IDW-1:0] id; logic last;} oexp_t;
  typedef struct {int id; logic [7:0] data; logic hold; logic last; int exp_grant;} vec_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req_valid, req_hold, req_last, req_ready;
  logic [NREQ*DW-1:0] req_data;
  logic [DW-1:0]      c_din, c_dout = '0, out_data;
  logic               c_den, c_hold, c_rdy = 1'b1, c_vldo = 1'b0;
  logic               out_valid, out_last, busy, err;
  logic [IDW-1:0]     out_id, grant_id;

  beat_t           drv [NREQ];
  logic [NREQ-1:0] drv_valid = '0;
  beat_t           q_src [NREQ][$];
  beat_t           q_cdin [$];
  logic [IDW:0]    q_tag [$];
  oexp_t           q_out [$];
  int              acc_id [$];
  int              acc_cyc [$];
  int              cyc = 0, pend = 0, pend_n;
  bit              auto_vldo = 1'b1, vldo_force = 1'b0, exp_err = 1'b0;
  int              checks = 0, errors = 0;
  beat_t           mb;
  oexp_t           mo;
  logic [IDW:0]    mt;

  always #5 clk = ~clk;

  assign req_valid = drv_valid;
  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      req_data[i*DW +: DW] = drv[i].data;
      req_hold[i]          = drv[i].hold;
      req_last[i]          = drv[i].last;
    end
  end

  data_compress_arb #(.NREQ(NREQ), .DW(DW), .TAG_DEPTH(TAG_DEPTH), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_hold(req_hold), .req_last(req_last), .req_ready(req_ready),
    .c_din(c_din), .c_den(c_den), .c_hold(c_hold), .c_rdy(c_rdy),
    .c_dout(c_dout), .c_vldo(c_vldo), .out_data(out_data), .out_valid(out_valid),
    .out_id(out_id), .out_last(out_last), .grant_id(grant_id), .busy(busy), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Fake compressor: one vldo per beat it has seen (auto), or forced pulses.
  always @(posedge clk) begin
    #2;
    if (rst) begin
      pend   = 0;
      c_vldo = 1'b0;
    end else begin
      pend_n = pend + (c_den ? 1 : 0);
      c_vldo = auto_vldo ? (pend_n > 0) : vldo_force;
      if (c_vldo && pend_n > 0) pend_n--;
      pend   = pend_n;
      c_dout = c_din ^ 8'h5A;
    end
  end

  // Scoreboard: push on acceptance/vldo, pop-and-compare on c_den/out_valid.
  always @(negedge clk) begin
    if (!rst) begin
      chk("err_flag", err, exp_err);
      if (out_valid) begin
        if (q_out.size() == 0) chk("out_unexpected", out_valid, 1'b0);
        else begin
          mo = q_out.pop_front();
          chk("out_data", out_data, mo.data);
          chk("out_id", out_id, mo.id);
          chk("out_last", out_last, mo.last);
        end
      end
      if (c_vldo) begin
        if (q_tag.size() > 0) begin
          mt      = q_tag.pop_front();
          mo.data = c_dout;
          mo.id   = mt[IDW:1];
          mo.last = mt[0];
          q_out.push_back(mo);
        end else begin
          exp_err = 1'b1;
        end
      end
      if (c_den) begin
        if (q_cdin.size() == 0) chk("cden_unexpected", c_den, 1'b0);
        else begin
          mb = q_cdin.pop_front();
          chk("c_din", c_din, mb.data);
          chk("c_hold", c_hold, mb.hold);
        end
      end
      for (int i = 0; i < int'(NREQ); i++) begin
        if (drv_valid[i] && req_ready[i]) begin
          q_cdin.push_back(drv[i]);
          q_tag.push_back({IDW'(i), drv[i].last});
          acc_id.push_back(i);
          acc_cyc.push_back(cyc);
        end
      end
    end
  end

  // One cycle: present queue heads at posedge+1, retire accepted beats.
  task automatic step();
    for (int i = 0; i < int'(NREQ); i++) begin
      if (q_src[i].size() > 0) begin
        drv_valid[i] = 1'b1;
        drv[i]       = q_src[i][0];
      end else begin
        drv_valid[i] = 1'b0;
      end
    end
    @(negedge clk);
    for (int i = 0; i < int'(NREQ); i++)
      if (!rst && drv_valid[i] && req_ready[i]) void'(q_src[i].pop_front());
    @(posedge clk);
    #1;
  endtask

  function automatic bit all_idle();
    bit idle = (q_cdin.size() == 0) && (q_tag.size() == 0) && (q_out.size() == 0);
    for (int i = 0; i < int'(NREQ); i++) if (q_src[i].size() != 0) idle = 1'b0;
    return idle;
  endfunction

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (!all_idle() && n < budget) begin
      step();
      n++;
    end
    chk(name, 32'(n < budget), 1);
    repeat (2) step();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    drv_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) q_src[i].delete();
    q_cdin.delete(); q_tag.delete(); q_out.delete();
    acc_id.delete(); acc_cyc.delete();
    exp_err = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_c_din"}, c_din, 0);
    chk({tag, "_c_den"}, c_den, 0);
    chk({tag, "_c_hold"}, c_hold, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_id"}, out_id, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
    @(posedge clk);
    #1;
  endtask

  function automatic beat_t rnd_beat(input bit last);
    beat_t b;
    b.data = 8'($urandom_range(0, 255));
    b.hold = 1'($urandom_range(0, 1));
    b.last = last;
    return b;
  endfunction

  vec_t  t1 [4];
  int    t2_exp [6];
  int    t3_exp [8];
  beat_t b;

  initial begin
    for (int i = 0; i < int'(NREQ); i++) drv[i] = '0;
    t1[0] = '{1, 8'h3F, 1'b0, 1'b0, 1};
    t1[1] = '{1, 8'h0F, 1'b1, 1'b0, 1};
    t1[2] = '{1, 8'h2F, 1'b0, 1'b0, 1};
    t1[3] = '{1, 8'h8F, 1'b0, 1'b1, 1};
    t2_exp = '{0, 0, 0, 2, 2, 2};
    t3_exp = '{0, 1, 2, 3, 0, 1, 2, 3};

    repeat (2) @(posedge clk);
    #1;
    do_reset();
    check_reset_outputs("rst0");

    // Single requester, table-driven beats.
    for (int k = 0; k < 4; k++) begin
      b.data = t1[k].data; b.hold = t1[k].hold; b.last = t1[k].last;
      q_src[t1[k].id].push_back(b);
    end
    drain("t1_drain", 60);
    chk("t1_beats", acc_id.size(), 4);
    for (int k = 0; k < 4; k++)
      chk("t1_grant", (k < acc_id.size()) ? acc_id[k] : -1, t1[k].exp_grant);
    if (acc_cyc.size() == 4) chk("t1_contiguous", acc_cyc[3] - acc_cyc[0], 3);
    chk("t1_grant_id", grant_id, 1);

    // Two requesters, packets must not interleave.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      q_src[0].push_back(rnd_beat(k == 2));
      q_src[2].push_back(rnd_beat(k == 2));
    end
    drain("t2_drain", 80);
    chk("t2_beats", acc_id.size(), 6);
    for (int k = 0; k < 6; k++)
      chk("t2_order", (k < acc_id.size()) ? acc_id[k] : -1, t2_exp[k]);
    if (acc_cyc.size() == 6) chk("t2_gap", acc_cyc[3] - acc_cyc[2], 3);

    // All requesters, 1-beat packets: round-robin order.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < int'(NREQ); i++) q_src[i].push_back(rnd_beat(1'b1));
    drain("t3_drain", 120);
    for (int k = 0; k < 8; k++)
      chk("t3_order", (k < acc_id.size()) ? acc_id[k] : -1, t3_exp[k]);

    // Tag FIFO full: ready drops after TAG_DEPTH beats; one vldo frees one slot.
    do_reset();
    auto_vldo = 1'b0;
    for (int k = 0; k < 6; k++) q_src[0].push_back(rnd_beat(k == 5));
    repeat (10) step();
    chk("t4_acc_full", acc_id.size(), TAG_DEPTH);
    @(negedge clk);
    chk("t4_ready_gated", req_ready[0], 1'b0);
    chk("t4_busy", busy, 1'b1);
    @(posedge clk);
    #1;
    vldo_force = 1'b1;
    step();
    vldo_force = 1'b0;
    repeat (6) step();
    chk("t4_acc_one_more", acc_id.size(), TAG_DEPTH + 1);
    auto_vldo = 1'b1;
    drain("t4_drain", 60);
    chk("t4_acc_total", acc_id.size(), 6);

    // vldo with empty tag FIFO: sticky err, no output.
    auto_vldo  = 1'b0;
    vldo_force = 1'b1;
    step();
    vldo_force = 1'b0;
    repeat (2) step();
    chk("t5_err_set", err, 1'b1);
    repeat (4) step();
    chk("t5_err_sticky", err, 1'b1);
    auto_vldo = 1'b1;
    do_reset();
    check_reset_outputs("t5_rst");

    // Reset mid-packet, then requester 3 is served first.
    for (int k = 0; k < 4; k++) q_src[1].push_back(rnd_beat(k == 3));
    for (int n = 0; n < 20 && acc_id.size() < 2; n++) step();
    chk("t6_mid_packet", acc_id.size(), 2);
    do_reset();
    check_reset_outputs("t6_rst");
    for (int k = 0; k < 2; k++) q_src[3].push_back(rnd_beat(k == 1));
    drain("t6_drain", 60);
    chk("t6_first_grant", (acc_id.size() > 0) ? acc_id[0] : -1, 3);
    chk("t6_grant_id", grant_id, 3);

    chk("final_queues", q_out.size() + q_tag.size() + q_cdin.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
